// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad column scanner.
// Key codes are row*4 + col; column drive is active-low one-hot.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } scan_state_t;

    function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    function automatic logic [3:0] col_onehot_n(input logic [1:0] col);
        logic [3:0] v;
        v      = 4'b1111;
        v[col] = 1'b0;
        return v;
    endfunction

    // Scanning downward lets the lowest low row overwrite any higher one.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Row/column/key signals between the scanner and the debounce and key-consumer logic.
// The master side is the scanner itself.
interface keypad_scanner_if;
    logic [3:0] rows_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_dwell_timer.sv
// Column dwell timer: counts 0..DWELL-1 while enabled, clear has priority.
// Terminal count flags the only cycle in which rows are trusted.
module keypad_dwell_timer #(
    parameter int DWELL = 16384
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = (count_q == TC_VAL);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one column per dwell period, accepts the
// first press seen at terminal count and freezes until all rows release.
//
//   state | meaning
//   SCAN  | column driven, dwell timer running, rows checked at terminal count
//   HOLD  | key accepted, column frozen, waiting for every row to go high
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DWELL = 16384
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);

    scan_state_t state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  col_n_q, col_n_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic        tmr_clr, tmr_en, tmr_tc;
    logic        rows_idle;

    assign rows_idle = &kp.rows_n;

    keypad_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            SCAN: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    if (rows_idle) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        state_d = HOLD;
                        code_d  = key_code_f(lowest_low_row(kp.rows_n), col_q);
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                tmr_clr = 1'b1;
                if (rows_idle) begin
                    state_d = SCAN;
                    held_d  = 1'b0;
                    col_d   = col_q + 2'd1;
                end
            end
            default: begin
                state_d = SCAN;
                tmr_clr = 1'b1;
            end
        endcase

        col_n_d = col_onehot_n(col_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            col_n_q <= 4'b1110;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            col_n_q <= col_n_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign kp.col_n     = col_n_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with DWELL=16: a keypad plant with 3-cycle row lag,
// a timeline reference model, table-driven presses, corner sequences and random presses.
module tb_keypad_scanner;

    localparam int DWELL = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(.DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    int checks = 0;
    int failures = 0;

    // plant: pressed[r*4+c] means key (r,c) is physically down
    logic [15:0] pressed = '0;
    bit          ovr_en = 0;
    logic [3:0]  ovr_val = 4'hF;
    int          lag = 0;
    logic [3:0]  prev_col_n = 4'b1110;
    int          nv = 0;

    // reference model: column index and cycles spent in it
    int         m_col, m_t;
    bit         m_hold, m_valid, m_held;
    logic [3:0] m_code;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic [3:0]  code;
        int          col;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_col_n(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c % 4] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_col = 0; m_t = 0; m_hold = 0; m_valid = 0; m_held = 0; m_code = 4'd0;
    endtask

    task automatic model_step(input logic [3:0] rows);
        int low;
        low = -1;
        for (int r = 3; r >= 0; r--) if (!rows[r]) low = r;
        m_valid = 0;
        if (m_hold) begin
            if (low < 0) begin
                m_hold = 0; m_held = 0; m_col = (m_col + 1) % 4; m_t = 0;
            end
        end else if (m_t == DWELL - 1) begin
            m_t = 0;
            if (low < 0) begin
                m_col = (m_col + 1) % 4;
            end else begin
                m_hold = 1; m_held = 1; m_valid = 1;
                m_code = 4'(low * 4 + m_col);
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic plant();
        logic [3:0] rows;
        if (kif.col_n != prev_col_n) lag = 0;
        else if (lag < 1000) lag++;
        prev_col_n = kif.col_n;
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!kif.col_n[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[r*4+c] && lag >= 3) rows[r] = 1'b0;
        if (ovr_en) rows = ovr_val;
        kif.rows_n = rows;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(kif.rows_n);
        #1;
        check("col_n", int'(kif.col_n), int'(exp_col_n(m_col)));
        check("key_code", int'(kif.key_code), int'(m_code));
        check("key_valid", int'(kif.key_valid), int'(m_valid));
        check("key_held", int'(kif.key_held), int'(m_held));
        if (kif.key_valid) nv++;
        plant();
    endtask

    task automatic wait_accept(input string name, input int budget);
        int n;
        n = 0;
        while (!kif.key_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(kif.key_valid), 1);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{keys: 16'h0200, hold: 10*DWELL, code: 4'd9,  col: 1};
        vecs[1] = '{keys: 16'h0001, hold: 20,       code: 4'd0,  col: 0};
        vecs[2] = '{keys: 16'h8080, hold: 30,       code: 4'd7,  col: 3};
        vecs[3] = '{keys: 16'h8000, hold: 5,        code: 4'd15, col: 3};
        vecs[4] = '{keys: 16'h0040, hold: 40,       code: 4'd6,  col: 2};

        kif.rows_n = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_n", int'(kif.col_n), 4'hE);
        check("rst_valid", int'(kif.key_valid), 0);
        check("rst_held", int'(kif.key_held), 0);
        check("rst_code", int'(kif.key_code), 0);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        prev_col_n = kif.col_n;
        lag = 0;

        // idle scan: column k/16 after the k-th edge
        for (int i = 0; i < 5*DWELL; i++) begin
            tick();
            check("scan_seq", int'(kif.col_n), int'(exp_col_n(((i + 1) / DWELL) % 4)));
        end

        foreach (vecs[v]) begin
            pressed = vecs[v].keys;
            nv = 0;
            wait_accept("accept", 5*DWELL);
            check("vec_code", int'(kif.key_code), int'(vecs[v].code));
            check("vec_held", int'(kif.key_held), 1);
            check("vec_frozen", int'(kif.col_n), int'(exp_col_n(vecs[v].col)));
            nv = 0;
            repeat (vecs[v].hold) tick();
            check("no_extra_valid", nv, 0);
            check("still_frozen", int'(kif.col_n), int'(exp_col_n(vecs[v].col)));
            pressed = '0;
            plant();
            tick();
            check("release_held", int'(kif.key_held), 0);
            check("release_col", int'(kif.col_n), int'(exp_col_n(vecs[v].col + 1)));
            repeat (4) tick();
        end

        // stale row: low only while column 2 counts 0..5
        begin
            int n;
            n = 0;
            while (!(m_col == 2 && m_t == 0 && !m_hold) && n < 5*DWELL) begin tick(); n++; end
            check("stale_reach", m_col, 2);
            nv = 0;
            ovr_en = 1; ovr_val = 4'b1011;
            plant();
            repeat (6) tick();
            ovr_val = 4'hF;
            plant();
            n = 0;
            while (m_col == 2 && n < 2*DWELL) begin tick(); n++; end
            check("stale_no_valid", nv, 0);
            check("stale_next_col", int'(kif.col_n), 4'b0111);
            ovr_en = 0;
        end

        // reset during HOLD, key stays pressed
        pressed = 16'h0200;
        wait_accept("pre_rst_accept", 5*DWELL);
        repeat (5) tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_col_n", int'(kif.col_n), 4'hE);
        check("async_valid", int'(kif.key_valid), 0);
        check("async_held", int'(kif.key_held), 0);
        check("async_code", int'(kif.key_code), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        plant();
        nv = 0;
        wait_accept("reaccept", 3*DWELL);
        check("reaccept_code", int'(kif.key_code), 9);
        check("reaccept_count", nv, 1);
        pressed = '0;
        plant();
        repeat (3) tick();

        // random presses, model checks every cycle
        for (int it = 0; it < 14; it++) begin
            int r1, r2, c;
            r1 = $urandom_range(0, 3);
            r2 = $urandom_range(0, 3);
            c  = $urandom_range(0, 3);
            pressed = '0;
            pressed[r1*4+c] = 1'b1;
            if ($urandom_range(0, 2) == 0) pressed[r2*4+c] = 1'b1;
            repeat ($urandom_range(1, 90)) tick();
            pressed = '0;
            plant();
            repeat ($urandom_range(1, 40)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
